// File: rtl/if_fetch_queue.sv
// if_fetch_queue: sequential instruction fetch, one outstanding memory request, DEPTH-entry queue to ID.
// Optional macro IF_BYPASS_EN forwards a returning instruction straight to ID while the queue is empty.
module if_fetch_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_busy_in,
  input  logic              mem_done_in,
  input  logic [INST_W-1:0] mem_inst_in,
  input  logic              branch_flag_in,
  input  logic [ADDR_W-1:0] branch_target_addr_in,
  input  logic              id_ready_in,
  output logic              if_valid_out,
  output logic [ADDR_W-1:0] if_pc_out,
  output logic [INST_W-1:0] if_inst_out,
  output logic              stall_req_from_if
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  entry_t            fifo [DEPTH];

  logic              head_valid;
  logic              bypass;
  logic              accept;
  logic              done_wait;
  logic              push;
  logic              pop_q;
  logic              in_flight;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W-1:0] seq_pc;
  entry_t            head;

  assign head_valid = (count != '0);
  assign accept     = mem_req_out && !mem_busy_in;
  assign done_wait  = (state == WAIT) && mem_done_in;
  assign seq_pc     = req_pc + ADDR_W'(4);

`ifdef IF_BYPASS_EN
  assign bypass = rst_in && done_wait && !branch_flag_in && !head_valid;
`else
  assign bypass = 1'b0;
`endif

  // Head of queue, or the returning instruction when it is forwarded directly.
  always_comb begin
    head = '0;
    if (head_valid) begin
      head = fifo[rd_ptr];
    end else if (bypass) begin
      head.pc   = req_pc;
      head.inst = mem_inst_in;
    end
  end

  assign if_valid_out      = head_valid || bypass;
  assign if_pc_out         = head.pc;
  assign if_inst_out       = head.inst;
  assign stall_req_from_if = !if_valid_out;

  assign pop_q      = head_valid && id_ready_in && !branch_flag_in;
  assign push       = rst_in && done_wait && !branch_flag_in && !(bypass && id_ready_in);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop_q);

  // A redirect must let an already-accepted fetch drain before issuing to the target.
  assign in_flight = ((state == WAIT) && !mem_done_in) ||
                     ((state == REQ)  && accept) ||
                     ((state == DROP) && !mem_done_in);

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo[wr_ptr].pc   <= req_pc;
      fifo[wr_ptr].inst <= mem_inst_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      req_pc       <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      mem_req_out  <= 1'b0;
      mem_addr_out <= '0;
    end else if (branch_flag_in) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= branch_target_addr_in;
      if (in_flight) begin
        state       <= DROP;
        mem_req_out <= 1'b0;
      end else begin
        state        <= REQ;
        mem_req_out  <= 1'b1;
        mem_addr_out <= branch_target_addr_in;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_q) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      case (state)
        IDLE: begin
          if (count < CNT_W'(DEPTH)) begin
            state        <= REQ;
            mem_req_out  <= 1'b1;
            mem_addr_out <= fetch_pc;
          end
        end
        REQ: begin
          if (accept) begin
            state       <= WAIT;
            mem_req_out <= 1'b0;
            req_pc      <= mem_addr_out;
          end
        end
        WAIT: begin
          if (mem_done_in) begin
            fetch_pc <= seq_pc;
            if (count_next < CNT_W'(DEPTH)) begin
              state        <= REQ;
              mem_req_out  <= 1'b1;
              mem_addr_out <= seq_pc;
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (mem_done_in) begin
            state        <= REQ;
            mem_req_out  <= 1'b1;
            mem_addr_out <= fetch_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
